// File: rtl/mips_debug_pkg.sv
// Shared debug-path constants and serializer state encoding.
// Optional macro: DEBUG_TX_CHECKSUM_EN adds the checksum states.
package mips_debug_pkg;

    localparam int DEF_BITS_SIZE  = 32;
    localparam int DEF_SIZE_TRAMA = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int BYTES_PER_WORD = DEF_BITS_SIZE / DEF_SIZE_TRAMA;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        START      = 3'd2,
`ifdef DEBUG_TX_CHECKSUM_EN
        WAIT_DONE  = 3'd3,
        CSUM_START = 3'd4,
        CSUM_WAIT  = 3'd5
`else
        WAIT_DONE  = 3'd3
`endif
    } ser_state_t;

    function automatic int bytes_per_word(input int bits, input int trama);
        return bits / trama;
    endfunction

endpackage

// File: rtl/debug_tx_serializer_if.sv
// Word push side and UART byte side of the debug serializer.
// Optional macro: DEBUG_TX_CHECKSUM_EN (no effect on this file).
interface debug_tx_serializer_if
    import mips_debug_pkg::*;
#(
    parameter int BITS_SIZE  = DEF_BITS_SIZE,
    parameter int SIZE_TRAMA = DEF_SIZE_TRAMA,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    logic                          i_word_valid;
    logic [BITS_SIZE-1:0]          i_word;
    logic                          o_word_ready;
    logic                          i_uart_tx_done;
    logic                          o_tx_start;
    logic [SIZE_TRAMA-1:0]         o_tx_data;
    logic                          o_busy;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

    modport master (
        output i_word_valid, i_word, i_uart_tx_done,
        input  o_word_ready, o_tx_start, o_tx_data, o_busy, o_fifo_count
    );

    modport slave (
        input  i_word_valid, i_word, i_uart_tx_done,
        output o_word_ready, o_tx_start, o_tx_data, o_busy, o_fifo_count
    );
endinterface

// File: rtl/debug_word_fifo.sv
// Synchronous word FIFO, DEPTH x WIDTH, head visible combinationally.
// Optional macro: DEBUG_TX_CHECKSUM_EN (no effect on this file).
module debug_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-pop count, so a full push is dropped.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage, power-of-two pointers wrap naturally, occupancy count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case (1'b1)
                push_ok & ~pop_ok: count <= count + 1'b1;
                pop_ok & ~push_ok: count <= count - 1'b1;
                default:           count <= count;
            endcase
        end
    end
endmodule

// File: rtl/debug_tx_serializer.sv
// Debug word to UART byte bridge: FIFO plus LSB-first byte serializer.
// Optional macro: DEBUG_TX_CHECKSUM_EN appends an XOR byte per word.
module debug_tx_serializer
    import mips_debug_pkg::*;
#(
    parameter int BITS_SIZE  = DEF_BITS_SIZE,
    parameter int SIZE_TRAMA = DEF_SIZE_TRAMA,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    debug_tx_serializer_if.slave  bus
);
    localparam int BYTES = bytes_per_word(BITS_SIZE, SIZE_TRAMA);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    ser_state_t                  state;
    logic [BITS_SIZE-1:0]        shift_q;
    logic [BITS_SIZE-1:0]        shift_nx;
    logic [IDX_W-1:0]            byte_idx;
    logic                        tx_start_q;
    logic [SIZE_TRAMA-1:0]       tx_data_q;
    logic [BITS_SIZE-1:0]        head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef DEBUG_TX_CHECKSUM_EN
    logic [SIZE_TRAMA-1:0]       csum_q;
`endif

    debug_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BITS_SIZE)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (bus.i_word_valid),
        .wdata   (bus.i_word),
        .pop     (state == LOAD),
        .rdata   (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign shift_nx         = shift_q >> SIZE_TRAMA;
    assign bus.o_word_ready = ~fifo_full;
    assign bus.o_fifo_count = fifo_count;
    assign bus.o_tx_start   = tx_start_q;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_busy       = ~fifo_empty | (state != IDLE);

    // Serializer FSM: start/data are registered on entry to a start state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            byte_idx   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) state <= LOAD;
                end
                LOAD: begin
                    shift_q    <= head;
                    byte_idx   <= '0;
                    tx_data_q  <= head[SIZE_TRAMA-1:0];
                    tx_start_q <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                    csum_q     <= '0;
`endif
                    state      <= START;
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_uart_tx_done) begin
                        shift_q  <= shift_nx;
                        byte_idx <= byte_idx + 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
                        csum_q   <= csum_q ^ shift_q[SIZE_TRAMA-1:0];
`endif
                        if (byte_idx == LAST_IDX) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                            tx_data_q  <= csum_q ^ shift_q[SIZE_TRAMA-1:0];
                            tx_start_q <= 1'b1;
                            state      <= CSUM_START;
`else
                            state <= fifo_empty ? IDLE : LOAD;
`endif
                        end else begin
                            tx_data_q  <= shift_nx[SIZE_TRAMA-1:0];
                            tx_start_q <= 1'b1;
                            state      <= START;
                        end
                    end
                end
`ifdef DEBUG_TX_CHECKSUM_EN
                CSUM_START: begin
                    state <= CSUM_WAIT;
                end
                CSUM_WAIT: begin
                    if (bus.i_uart_tx_done) begin
                        state <= fifo_empty ? IDLE : LOAD;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench for debug_tx_serializer with a hand-driven UART side.
// Optional macro: DEBUG_TX_CHECKSUM_EN expects one XOR byte per word.
module tb_debug_tx_serializer;

`ifdef DEBUG_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic [7:0] log_q[$];

    always #5 clk = ~clk;

    debug_tx_serializer_if bus ();

    debug_tx_serializer dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    // Record every byte the DUT launches.
    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) log_q.push_back(bus.o_tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bus.i_word_valid = 1'b1;
        bus.i_word       = w;
        tick();
        bus.i_word_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.o_tx_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 32'(bus.o_tx_start), 32'd1);
    endtask

    task automatic done_pulse();
        bus.i_uart_tx_done = 1'b1;
        tick();
        bus.i_uart_tx_done = 1'b0;
    endtask

    // Hand each byte back with done 5 cycles after its start.
    task automatic serve(input string tag, input logic [31:0] w,
                         input logic [7:0] cs, input int first,
                         input bit last);
        logic [7:0] e;
        for (int i = first; i < NB; i++) begin
            e = (i < 4) ? 8'(w >> (8 * i)) : cs;
            wait_start(tag);
            chk({tag, "_byte"}, 32'(bus.o_tx_data), 32'(e));
            tick();
            chk({tag, "_pulse"}, 32'(bus.o_tx_start), 32'd0);
            repeat (3) tick();
            done_pulse();
            if (i < NB - 1) chk({tag, "_gap"}, 32'(bus.o_tx_start), 32'd1);
        end
        if (last) chk({tag, "_busy_fall"}, 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        int bad;
        bus.i_word_valid   = 1'b0;
        bus.i_word         = '0;
        bus.i_uart_tx_done = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(bus.o_word_ready), 32'd1);
        chk("rst_start", 32'(bus.o_tx_start), 32'd0);
        chk("rst_data", 32'(bus.o_tx_data), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_count", 32'(bus.o_fifo_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency and byte order
        log_q.delete();
        push(32'h1234_5678);
        chk("lat_count", 32'(bus.o_fifo_count), 32'd1);
        chk("lat_busy", 32'(bus.o_busy), 32'd1);
        tick();
        chk("lat_load", 32'(bus.o_tx_start), 32'd0);
        tick();
        chk("lat_start", 32'(bus.o_tx_start), 32'd1);
        serve("w1", 32'h1234_5678, 8'h08, 0, 1'b1);
        chk("w1_frames", 32'(log_q.size()), 32'(NB));

        // Spurious done while idle
        log_q.delete();
        done_pulse();
        tick();
        chk("idle_busy", 32'(bus.o_busy), 32'd0);
        chk("idle_start", 32'(bus.o_tx_start), 32'd0);
        chk("idle_frames", 32'(log_q.size()), 32'd0);

        // Reset in the middle of a word
        push(32'hCAFE_BABE);
        wait_start("pre_rst");
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", 32'(bus.o_word_ready), 32'd1);
        chk("mid_rst_start", 32'(bus.o_tx_start), 32'd0);
        chk("mid_rst_data", 32'(bus.o_tx_data), 32'd0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_count", 32'(bus.o_fifo_count), 32'd0);
        rst_n = 1'b1;
        tick();
        log_q.delete();
        push(32'h0000_0001);
        serve("after_rst", 32'h0000_0001, 8'h01, 0, 1'b1);
        chk("after_rst_frames", 32'(log_q.size()), 32'(NB));

        // Fill while UART stalls, push/pop overlap, overflow drop
        log_q.delete();
        bus.i_word_valid = 1'b1;
        bus.i_word = 32'h1122_3344;
        tick();
        chk("fill_c1", 32'(bus.o_fifo_count), 32'd1);
        bus.i_word = 32'h5566_7788;
        tick();
        chk("fill_c2", 32'(bus.o_fifo_count), 32'd2);
        bus.i_word = 32'h99AA_BBCC;
        tick();
        chk("push_pop_c2", 32'(bus.o_fifo_count), 32'd2);
        bus.i_word = 32'h0102_0304;
        tick();
        chk("fill_c3", 32'(bus.o_fifo_count), 32'd3);
        bus.i_word = 32'h1020_3040;
        tick();
        chk("fill_c4", 32'(bus.o_fifo_count), 32'd4);
        chk("full_ready", 32'(bus.o_word_ready), 32'd0);
        bus.i_word = 32'hDEAD_BEEF;
        tick();
        bus.i_word_valid = 1'b0;
        chk("drop_count", 32'(bus.o_fifo_count), 32'd4);
        chk("drop_ready", 32'(bus.o_word_ready), 32'd0);
        chk("w0_b0", 32'(bus.o_tx_data), 32'h44);
        done_pulse();
        chk("w0_gap", 32'(bus.o_tx_start), 32'd1);
        serve("w0", 32'h1122_3344, 8'h44, 1, 1'b0);
        serve("w1q", 32'h5566_7788, 8'hCC, 0, 1'b0);
        serve("w2q", 32'h99AA_BBCC, 8'h44, 0, 1'b0);
        serve("w3q", 32'h0102_0304, 8'h04, 0, 1'b0);
        serve("w4q", 32'h1020_3040, 8'h40, 0, 1'b1);
        chk("fill_frames", 32'(log_q.size()), 32'(5 * NB));
        bad = 0;
        foreach (log_q[k]) begin
            if (log_q[k] == 8'hDE || log_q[k] == 8'hAD ||
                log_q[k] == 8'hBE || log_q[k] == 8'hEF) bad++;
        end
        chk("drop_absent", 32'(bad), 32'd0);

        // Spurious done during START
        log_q.delete();
        push(32'hA1B2_C3D4);
        wait_start("sp");
        done_pulse();
        chk("sp_start", 32'(bus.o_tx_start), 32'd0);
        chk("sp_hold", 32'(bus.o_tx_data), 32'hD4);
        repeat (2) tick();
        done_pulse();
        chk("sp_gap", 32'(bus.o_tx_start), 32'd1);
        chk("sp_b1", 32'(bus.o_tx_data), 32'hC3);
        serve("sp", 32'hA1B2_C3D4, 8'h04, 1, 1'b1);
        chk("sp_frames", 32'(log_q.size()), 32'(NB));

        // Checksum vectors (plain words without the macro)
        push(32'hA5A5_0F0F);
        serve("cs1", 32'hA5A5_0F0F, 8'h00, 0, 1'b1);
        push(32'h0102_0304);
        serve("cs2", 32'h0102_0304, 8'h04, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
